hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 133 +++++++++++++
 tb/tb_hazard_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: scoreboard-based RAW hazard detection, stall/flush and operand forwarding select.
// Define HAZARD_CTRL_FORWARD_EN for forwarding (load-use stall only); otherwise stall on any EXE/MEM hit.
module hazard_ctrl (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] Instruction_ID,
   input  logic        branch,
   output logic        stall,
   output logic        flush,
   output logic [1:0]  fwd_a,
   output logic [1:0]  fwd_b,
   output logic [15:0] stall_count
);

   typedef struct packed {
      logic       valid;
      logic [4:0] dest;
      logic       is_load;
   } slot_t;

   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,
      FWD_MEM = 2'b01,
      FWD_WB  = 2'b10
   } fwd_sel_e;

   slot_t      exe_q, exe_d, mem_q, mem_d, wb_q, wb_d;
   fwd_sel_e   fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
   logic [15:0] stall_count_q, stall_count_d;

   logic [5:0] op;
   logic [4:0] rs, rt, rd;
   logic [4:0] src_a, src_b;
   slot_t      id_slot;
   logic       hit_exe;
   logic       raw_stall;

   assign op = Instruction_ID[31:26];
   assign rs = Instruction_ID[25:21];
   assign rt = Instruction_ID[20:16];
   assign rd = Instruction_ID[15:11];

   function automatic logic hits(input slot_t s, input logic [4:0] src);
      return s.valid && (src != 5'd0) && (s.dest == src);
   endfunction

`ifdef HAZARD_CTRL_FORWARD_EN
   function automatic fwd_sel_e pick(input logic [4:0] src, input slot_t exe, input slot_t mem);
      if (hits(exe, src)) return FWD_MEM;
      if (hits(mem, src)) return FWD_WB;
      return FWD_RF;
   endfunction
`endif

   // Source/destination decode; a source of 0 means "none" and never matches.
   always_comb begin
      id_slot = '0;
      src_a   = '0;
      src_b   = '0;
      if (Instruction_ID != '0 && op != 6'd2) src_a = rs;
      if (op == 6'd0 || op == 6'd43 || op == 6'd4) src_b = rt;
      case (op)
         6'd0:    if (Instruction_ID != '0) id_slot.dest = rd;
         6'd35:   begin
                     id_slot.dest    = rt;
                     id_slot.is_load = 1'b1;
                  end
         6'd8:    id_slot.dest = rt;
         default: id_slot.dest = '0;
      endcase
      id_slot.valid = (id_slot.dest != 5'd0);
      if (!id_slot.valid) id_slot.is_load = 1'b0;
   end

   always_comb begin
      hit_exe = hits(exe_q, src_a) | hits(exe_q, src_b);
`ifdef HAZARD_CTRL_FORWARD_EN
      raw_stall = hit_exe & exe_q.is_load;
`else
      raw_stall = hit_exe | hits(mem_q, src_a) | hits(mem_q, src_b);
`endif
      // Flush wins over stall; both are held low during reset.
      flush = reset & branch;
      stall = reset & ~branch & raw_stall;
   end

   always_comb begin
      wb_d          = mem_q;
      mem_d         = flush ? slot_t'('0) : exe_q;
      exe_d         = (stall | flush) ? slot_t'('0) : id_slot;
      fwd_a_d       = FWD_RF;
      fwd_b_d       = FWD_RF;
`ifdef HAZARD_CTRL_FORWARD_EN
      if (!(stall | flush)) begin
         fwd_a_d = pick(src_a, exe_q, mem_q);
         fwd_b_d = pick(src_b, exe_q, mem_q);
      end
`endif
      stall_count_d = stall_count_q;
      if (stall && stall_count_q != '1) stall_count_d = stall_count_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         exe_q         <= '0;
         mem_q         <= '0;
         wb_q          <= '0;
         fwd_a_q       <= FWD_RF;
         fwd_b_q       <= FWD_RF;
         stall_count_q <= '0;
      end else begin
         exe_q         <= exe_d;
         mem_q         <= mem_d;
         wb_q          <= wb_d;
         fwd_a_q       <= fwd_a_d;
         fwd_b_q       <= fwd_b_d;
         stall_count_q <= stall_count_d;
      end
   end

   assign fwd_a       = fwd_a_q;
   assign fwd_b       = fwd_b_q;
   assign stall_count = stall_count_q;

   // WB results are visible to the ID read, so the WB slot only tracks occupancy.
   function automatic logic slot_ok(input slot_t s);
      return (s.valid == (s.dest != 5'd0)) && (!s.is_load || s.valid);
   endfunction

   a_slots_consistent: assert property (@(posedge clk) disable iff (!reset)
      slot_ok(exe_q) && slot_ok(mem_q) && slot_ok(wb_q));

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed + random checks of hazard_ctrl against an instruction-level pipeline model.
module tb_hazard_ctrl;

`ifdef HAZARD_CTRL_FORWARD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] Instruction_ID = '0;
   logic        branch = 1'b0;
   logic        stall, flush;
   logic [1:0]  fwd_a, fwd_b;
   logic [15:0] stall_count;

   hazard_ctrl dut (
      .clk            (clk),
      .reset          (reset),
      .Instruction_ID (Instruction_ID),
      .branch         (branch),
      .stall          (stall),
      .flush          (flush),
      .fwd_a          (fwd_a),
      .fwd_b          (fwd_b),
      .stall_count    (stall_count)
   );

   always #5 clk = ~clk;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Model: the raw instruction words occupying EXE and MEM (0 = bubble).
   logic [31:0] m_exe = '0, m_mem = '0;
   logic [1:0]  m_fa = '0, m_fb = '0;
   logic [15:0] m_cnt = '0;

   function automatic logic [4:0] dest_of(input logic [31:0] w);
      logic [5:0] o = w[31:26];
      if (w == 32'd0) return 5'd0;
      if (o == 6'd0) return w[15:11];
      if (o == 6'd35 || o == 6'd8) return w[20:16];
      return 5'd0;
   endfunction

   function automatic logic [4:0] rs_read(input logic [31:0] w);
      return (w != 32'd0 && w[31:26] != 6'd2) ? w[25:21] : 5'd0;
   endfunction

   function automatic logic [4:0] rt_read(input logic [31:0] w);
      logic [5:0] o = w[31:26];
      return (o == 6'd0 || o == 6'd43 || o == 6'd4) ? w[20:16] : 5'd0;
   endfunction

   function automatic bit reads(input logic [31:0] w, input logic [4:0] r);
      return r != 5'd0 && (rs_read(w) == r || rt_read(w) == r);
   endfunction

   function automatic logic [1:0] src_fwd(input logic [4:0] r);
      if (r == 5'd0) return 2'b00;
      if (r == dest_of(m_exe)) return 2'b01;
      if (r == dest_of(m_mem)) return 2'b10;
      return 2'b00;
   endfunction

   task automatic step(input logic [31:0] id, input logic br, input logic rst, input string tag);
      bit he, hm, st, fl;
      @(negedge clk);
      Instruction_ID = id;
      branch         = br;
      reset          = rst;
      he = reads(id, dest_of(m_exe));
      hm = reads(id, dest_of(m_mem));
      fl = rst && br;
      if (FWD) st = rst && !br && he && m_exe[31:26] == 6'd35;
      else     st = rst && !br && (he || hm);
      #1;
      check({tag, ".stall"}, 32'(stall), 32'(st));
      check({tag, ".flush"}, 32'(flush), 32'(fl));
      @(posedge clk);
      if (!rst) begin
         m_exe = '0; m_mem = '0; m_fa = '0; m_fb = '0; m_cnt = '0;
      end else begin
         if (FWD && !st && !fl) begin
            m_fa = src_fwd(rs_read(id));
            m_fb = src_fwd(rt_read(id));
         end else begin
            m_fa = '0;
            m_fb = '0;
         end
         if (st && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
         m_mem = fl ? 32'd0 : m_exe;
         m_exe = (st || fl) ? 32'd0 : id;
      end
      #1;
      check({tag, ".fwd_a"}, 32'(fwd_a), 32'(m_fa));
      check({tag, ".fwd_b"}, 32'(fwd_b), 32'(m_fb));
      check({tag, ".count"}, 32'(stall_count), 32'(m_cnt));
   endtask

   function automatic logic [31:0] rand_instr();
      logic [5:0] o;
      case ($urandom_range(0, 7))
         0: o = 6'd0;
         1: o = 6'd35;
         2: o = 6'd8;
         3: o = 6'd43;
         4: o = 6'd4;
         5: o = 6'd2;
         6: o = 6'd13;
         default: return 32'd0;
      endcase
      return {o, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
              5'($urandom_range(0, 3)), 11'($urandom)};
   endfunction

   localparam logic [31:0] LW2   = 32'h8C220000;
   localparam logic [31:0] ADD3  = 32'h00441820;
   localparam logic [31:0] ADD5  = 32'h00632820;
   localparam logic [31:0] LW22  = 32'h8C420000;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      step(32'hFFFFFFFF, 1'b1, 1'b0, "rst0");
      step(ADD3, 1'b1, 1'b0, "rst1");
      check("rst.count", 32'(stall_count), 32'd0);
      check("rst.fwd_a", 32'(fwd_a), 32'd0);

      // Load-use
      step(32'd0, 1'b0, 1'b0, "lu.rst");
      step(LW2, 1'b0, 1'b1, "lu.lw");
      step(ADD3, 1'b0, 1'b1, "lu.use0");
      step(ADD3, 1'b0, 1'b1, "lu.use1");
`ifdef HAZARD_CTRL_FORWARD_EN
      check("lu.fwd_a_const", 32'(fwd_a), 32'd2);
      check("lu.fwd_b_const", 32'(fwd_b), 32'd0);
      check("lu.count_const", 32'(stall_count), 32'd1);
`else
      step(ADD3, 1'b0, 1'b1, "lu.use2");
      check("lu.count_const", 32'(stall_count), 32'd2);
      check("lu.fwd_a_const", 32'(fwd_a), 32'd0);
`endif

      // ALU chain
      step(32'd0, 1'b0, 1'b0, "alu.rst");
      step(ADD3, 1'b0, 1'b1, "alu.p");
      step(ADD5, 1'b0, 1'b1, "alu.c0");
`ifdef HAZARD_CTRL_FORWARD_EN
      check("alu.fwd_a_const", 32'(fwd_a), 32'd1);
      check("alu.fwd_b_const", 32'(fwd_b), 32'd1);
      check("alu.count_const", 32'(stall_count), 32'd0);
`else
      step(ADD5, 1'b0, 1'b1, "alu.c1");
      step(ADD5, 1'b0, 1'b1, "alu.c2");
      check("alu.count_const", 32'(stall_count), 32'd2);
      check("alu.fwd_a_const", 32'(fwd_a), 32'd0);
      check("alu.fwd_b_const", 32'(fwd_b), 32'd0);
`endif

      // Branch arriving while a load-use hazard is pending
      step(32'd0, 1'b0, 1'b0, "br.rst");
      step(LW2, 1'b0, 1'b1, "br.lw");
      step(ADD3, 1'b1, 1'b1, "br.flush");
      check("br.flush_const", 32'(flush), 32'd1);
      check("br.stall_const", 32'(stall), 32'd0);
      check("br.count_const", 32'(stall_count), 32'd0);
      step(ADD3, 1'b0, 1'b1, "br.after");
      check("br.after_count", 32'(stall_count), 32'd0);

      // Reset in the middle of a stall
      step(32'd0, 1'b0, 1'b0, "rm.rst");
      step(LW2, 1'b0, 1'b1, "rm.lw");
      step(ADD3, 1'b0, 1'b1, "rm.stall");
      step(ADD3, 1'b0, 1'b0, "rm.reset");
      step(ADD3, 1'b0, 1'b1, "rm.release");
      check("rm.count_const", 32'(stall_count), 32'd0);
      check("rm.fwd_a_const", 32'(fwd_a), 32'd0);

      // Saturation: preload the counter near the top, then keep stalling
      step(32'd0, 1'b0, 1'b0, "sat.rst");
      force dut.stall_count_q = 16'hFFF0;
      #1;
      release dut.stall_count_q;
      m_cnt = 16'hFFF0;
      check("sat.preload", 32'(stall_count), 32'h0000FFF0);
      for (int i = 0; i < 48; i++) step(LW22, 1'b0, 1'b1, "sat.run");
      check("sat.count_const", 32'(stall_count), 32'h0000FFFF);
      step(LW22, 1'b0, 1'b0, "sat.reset");
      check("sat.rst_count", 32'(stall_count), 32'd0);
      check("sat.rst_stall", 32'(stall), 32'd0);
      check("sat.rst_fwd_a", 32'(fwd_a), 32'd0);
      check("sat.rst_fwd_b", 32'(fwd_b), 32'd0);

      // Random traffic with a small register window to provoke hazards
      for (int i = 0; i < 1500; i++) begin
         step(rand_instr(), ($urandom_range(0, 9) == 0), ($urandom_range(0, 39) != 0), "rnd");
      end

      $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
      $finish;
   end

endmodule
